imem_port_arbiter: RTL

- Shares the single instruction-memory port between two requesters: the UART boot loader write master and the CPU instruction-fetch/data master.
- Ownership follows the boot loader's system-reset output (boot_mode). Ownership changes only after all outstanding memory transactions have drained, so no request or response crosses owners.
- Sits between the boot loader, the CPU bus and the instruction RAM. It also drives the CPU core hold.

---
 rtl/imem_port_arbiter.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/imem_port_arbiter.sv
// Instruction-memory port arbiter: hands the single RAM port to either the CPU or the
// UART boot loader, switching owners only after in-flight transactions drain.
module imem_port_arbiter #(
  parameter int AW            = 32,
  parameter int DW            = 32,
  parameter int MAX_OUTST     = 2,
  parameter int DRAIN_TIMEOUT = 1023
) (
  input  logic            Clk,
  input  logic            Rst,
  input  logic            boot_mode,
  input  logic            boot_req,
  input  logic            boot_we,
  input  logic [DW/8-1:0] boot_be,
  input  logic [AW-1:0]   boot_addr,
  input  logic [DW-1:0]   boot_wdata,
  output logic            boot_gnt,
  input  logic            cpu_req,
  input  logic            cpu_we,
  input  logic [DW/8-1:0] cpu_be,
  input  logic [AW-1:0]   cpu_addr,
  input  logic [DW-1:0]   cpu_wdata,
  output logic            cpu_gnt,
  output logic            cpu_rvalid,
  output logic [DW-1:0]   cpu_rdata,
  output logic            mem_req,
  output logic            mem_we,
  output logic [DW/8-1:0] mem_be,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  input  logic            mem_gnt,
  input  logic            mem_rvalid,
  input  logic [DW-1:0]   mem_rdata,
  output logic            cpu_hold,
  output logic            owner,
  output logic            boot_err,
  output logic            drain_err
);

  localparam logic [1:0] CPU_OWN  = 2'd0;
  localparam logic [1:0] DRAIN_B  = 2'd1;
  localparam logic [1:0] BOOT_OWN = 2'd2;
  localparam logic [1:0] DRAIN_C  = 2'd3;

  localparam int OW = $clog2(MAX_OUTST + 1);
  localparam int CW = (DRAIN_TIMEOUT > 1) ? $clog2(DRAIN_TIMEOUT + 1) : 1;

  logic [1:0]    state;
  logic [OW-1:0] outst;
  logic [CW-1:0] drain_cnt;
  logic          in_drain;
  logic          full;
  logic          timeout;
  logic          inc;
  logic          dec;

  assign in_drain = (state == DRAIN_B) || (state == DRAIN_C);
  assign full     = (outst == OW'(MAX_OUTST));
  // The counter reaches DRAIN_TIMEOUT on the edge that ends the timed-out drain cycle.
  assign timeout  = (DRAIN_TIMEOUT > 0) && in_drain && (outst != '0) &&
                    (drain_cnt == CW'(DRAIN_TIMEOUT - 1));
  assign inc      = mem_req && mem_gnt;
  assign dec      = mem_rvalid && (outst != '0);

  // NOTE: every output gets a default before the case so no latch can be inferred.
  always_comb begin
    mem_req   = 1'b0;
    cpu_gnt   = 1'b0;
    boot_gnt  = 1'b0;
    mem_we    = cpu_we;
    mem_be    = cpu_be;
    mem_addr  = cpu_addr;
    mem_wdata = cpu_wdata;
    if (state == BOOT_OWN) begin
      mem_we    = boot_we;
      mem_be    = boot_be;
      mem_addr  = boot_addr;
      mem_wdata = boot_wdata;
    end
    // Full gating looks only at registered outst, never at this cycle's mem_rvalid.
    if (!full) begin
      case (state)
        CPU_OWN: begin
          mem_req = cpu_req;
          cpu_gnt = mem_gnt;
        end
        BOOT_OWN: begin
          mem_req  = boot_req;
          boot_gnt = mem_gnt;
        end
        default: ;
      endcase
    end
  end

  assign cpu_rvalid = mem_rvalid && ((state == CPU_OWN) || (state == DRAIN_B));
  assign cpu_rdata  = mem_rdata;
  assign cpu_hold   = (state != CPU_OWN);
  assign owner      = (state == BOOT_OWN) || (state == DRAIN_C);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state     <= CPU_OWN;
      outst     <= '0;
      drain_cnt <= '0;
      boot_err  <= 1'b0;
      drain_err <= 1'b0;
    end else begin
      if (boot_req && (state != BOOT_OWN)) boot_err <= 1'b1;

      // Held at zero while owned, so every drain starts counting from zero.
      drain_cnt <= in_drain ? drain_cnt + 1'b1 : '0;

      if (timeout)           outst <= '0;
      else if (inc && !dec)  outst <= outst + 1'b1;
      else if (dec && !inc)  outst <= outst - 1'b1;

      case (state)
        CPU_OWN:  if (boot_mode) state <= DRAIN_B;
        DRAIN_B: begin
          if (outst == '0) state <= BOOT_OWN;
          else if (timeout) begin
            state     <= BOOT_OWN;
            drain_err <= 1'b1;
          end
        end
        BOOT_OWN: if (!boot_mode) state <= DRAIN_C;
        DRAIN_C: begin
          if (outst == '0) state <= CPU_OWN;
          else if (timeout) begin
            state     <= CPU_OWN;
            drain_err <= 1'b1;
          end
        end
        default:  state <= CPU_OWN;
      endcase
    end
  end

endmodule
